// File: rtl/noc_tx_scheduler_pkg.sv
// noc_tx_scheduler_pkg: shared defaults, flit type, channel indices and wrap helper for the tx scheduler
package noc_tx_scheduler_pkg;
  localparam int WORD_W_DEF = 32;
  localparam int WORDS_PER_FLIT_DEF = 4;
  localparam int FLIT_W_DEF = WORD_W_DEF * WORDS_PER_FLIT_DEF;
  localparam int NUM_CH_DEF = 3;
  localparam int DEPTH_DEF = 8;
  localparam int CH_ACK = 0;
  localparam int CH_FWD = 1;
  localparam int CH_LOCAL = 2;
  typedef logic [FLIT_W_DEF-1:0] flit_t;
  function automatic int next_idx(input int cur, input int n);
    return cur >= n - 1 ? 0 : cur + 1;
  endfunction
endpackage

// File: rtl/noc_flit_fifo.sv
// noc_flit_fifo: per-channel flit FIFO; full/empty come straight from the occupancy counter
module noc_flit_fifo #(
  parameter int DEPTH = 8,
  parameter int FLIT_W = 128
) (
  input  logic              nocclk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              push,
  input  logic [FLIT_W-1:0] push_data,
  input  logic              pop,
  output logic [FLIT_W-1:0] head_data,
  output logic              empty,
  output logic              full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [FLIT_W-1:0] mem [DEPTH];
  logic [AW-1:0] head, tail;
  logic [CW-1:0] count;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  // a full FIFO refuses the push even if it pops on the same edge
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign head_data = mem[head];
  always_ff @(posedge nocclk)
    if (do_push) mem[tail] <= push_data;
  always_ff @(posedge nocclk or negedge rst_n)
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else if (clear) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + AW'(1);
      if (do_pop) head <= head + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/noc_tx_scheduler.sv
// noc_tx_scheduler: word packer, per-channel flit FIFOs, strict/round-robin arbiter and registered output
module noc_tx_scheduler
  import noc_tx_scheduler_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int WORDS_PER_FLIT = WORDS_PER_FLIT_DEF,
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int RR_MODE = 0,
  localparam int FLIT_W = WORD_W * WORDS_PER_FLIT,
  localparam int CH_W = $clog2(NUM_CH)
) (
  input  logic                         nocclk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic [(NUM_CH-1)*FLIT_W-1:0] ext_flit,
  input  logic [NUM_CH-2:0]            ext_vld,
  output logic [NUM_CH-2:0]            ext_rdy,
  input  logic [WORD_W-1:0]            word_in,
  input  logic                         word_vld,
  output logic                         word_rdy,
  output logic [FLIT_W-1:0]            out_flit,
  output logic                         out_vld,
  output logic [CH_W-1:0]              out_ch,
  input  logic                         out_rdy,
  output logic [NUM_CH-1:0]            ch_empty,
  output logic [NUM_CH-1:0]            ch_full
);
  localparam int LAST = WORDS_PER_FLIT - 1;
  localparam int PW = WORDS_PER_FLIT > 1 ? $clog2(WORDS_PER_FLIT) : 1;
  logic [PW-1:0] pos;
  logic [FLIT_W-1:0] pack, packed_flit;
  logic [FLIT_W-1:0] push_data [NUM_CH];
  logic [FLIT_W-1:0] head_data [NUM_CH];
  logic [NUM_CH-1:0] push, pop;
  logic [CH_W-1:0] gnt, idx, start, last_grant;
  logic word_acc, last_acc, any, load, take;
  assign ext_rdy = ~ch_full[NUM_CH-2:0] & {(NUM_CH-1){!clear}};
  assign word_rdy = !(pos == PW'(LAST) && ch_full[NUM_CH-1]) && !clear;
  assign word_acc = word_vld && word_rdy;
  assign last_acc = word_acc && pos == PW'(LAST);
  assign push = {last_acc, ext_vld & ext_rdy};
  always_comb begin
    packed_flit = pack;
    for (int k = 0; k < WORDS_PER_FLIT; k++)
      if (pos == PW'(k)) packed_flit[k*WORD_W +: WORD_W] = word_in;
  end
  for (genvar i = 0; i < NUM_CH - 1; i++) begin : g_ext
    assign push_data[i] = ext_flit[i*FLIT_W +: FLIT_W];
  end
  assign push_data[NUM_CH-1] = packed_flit;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    noc_flit_fifo #(.DEPTH(DEPTH), .FLIT_W(FLIT_W)) u_fifo (
      .nocclk    (nocclk),
      .rst_n     (rst_n),
      .clear     (clear),
      .push      (push[i]),
      .push_data (push_data[i]),
      .pop       (pop[i]),
      .head_data (head_data[i]),
      .empty     (ch_empty[i]),
      .full      (ch_full[i])
    );
  end
  // scanning from the highest offset down leaves the first non-empty channel after start in gnt
  assign start = RR_MODE != 0 ? CH_W'(next_idx(int'(last_grant), NUM_CH)) : '0;
  always_comb begin
    any = 1'b0;
    gnt = '0;
    idx = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = CH_W'((int'(start) + k) % NUM_CH);
      if (!ch_empty[idx]) begin
        any = 1'b1;
        gnt = idx;
      end
    end
  end
  assign load = !out_vld || out_rdy;
  assign take = load && any && !clear;
  assign pop = take ? NUM_CH'(1) << gnt : '0;
  always_ff @(posedge nocclk or negedge rst_n)
    if (!rst_n) begin
      pos <= '0;
      pack <= '0;
      out_vld <= 1'b0;
      out_flit <= '0;
      out_ch <= '0;
      last_grant <= CH_W'(NUM_CH - 1);
    end else if (clear) begin
      pos <= '0;
      pack <= '0;
      out_vld <= 1'b0;
      out_flit <= '0;
      out_ch <= '0;
      last_grant <= CH_W'(NUM_CH - 1);
    end else begin
      if (word_acc) begin
        pack <= packed_flit;
        pos <= last_acc ? '0 : pos + PW'(1);
      end
      if (load) out_vld <= any;
      if (take) begin
        out_flit <= head_data[gnt];
        out_ch <= gnt;
        last_grant <= gnt;
      end
    end
endmodule

// File: tb/tb_noc_tx_scheduler.sv
// tb_noc_tx_scheduler: directed checks of packing, strict and round-robin arbitration, backpressure, clear and reset
module tb_noc_tx_scheduler;
  import noc_tx_scheduler_pkg::*;
  logic nocclk = 1'b0, rst_n = 1'b0, clear = 1'b0, word_vld = 1'b0, out_rdy = 1'b0;
  logic [2*FLIT_W_DEF-1:0] ext_flit = '0;
  logic [1:0] ext_vld = '0;
  logic [31:0] word_in = '0;
  logic [1:0] ext_rdy, ext_rdy_r, out_ch, out_ch_r;
  logic word_rdy, word_rdy_r, out_vld, out_vld_r;
  flit_t out_flit, out_flit_r;
  logic [2:0] ch_empty, ch_full, ch_empty_r, ch_full_r;
  int checks = 0, passed = 0, fails = 0;
  int exp_rr [9] = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
  int exp_st [9] = '{0, 0, 0, 1, 1, 1, 2, 2, 2};

  noc_tx_scheduler #(.RR_MODE(0)) dut (
    .nocclk(nocclk), .rst_n(rst_n), .clear(clear), .ext_flit(ext_flit), .ext_vld(ext_vld),
    .ext_rdy(ext_rdy), .word_in(word_in), .word_vld(word_vld), .word_rdy(word_rdy),
    .out_flit(out_flit), .out_vld(out_vld), .out_ch(out_ch), .out_rdy(out_rdy),
    .ch_empty(ch_empty), .ch_full(ch_full));

  noc_tx_scheduler #(.RR_MODE(1)) dut_rr (
    .nocclk(nocclk), .rst_n(rst_n), .clear(clear), .ext_flit(ext_flit), .ext_vld(ext_vld),
    .ext_rdy(ext_rdy_r), .word_in(word_in), .word_vld(word_vld), .word_rdy(word_rdy_r),
    .out_flit(out_flit_r), .out_vld(out_vld_r), .out_ch(out_ch_r), .out_rdy(out_rdy),
    .ch_empty(ch_empty_r), .ch_full(ch_full_r));

  always #5 nocclk = ~nocclk;

  task automatic step();
    @(posedge nocclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    word_in = w;
    word_vld = 1'b1;
    step();
    word_vld = 1'b0;
  endtask

  task automatic check_reset(input string t);
    check({t, "_vld"}, out_vld, 0);
    check({t, "_flit"}, out_flit, 0);
    check({t, "_ch"}, out_ch, 0);
    check({t, "_ext_rdy"}, ext_rdy, 2'b11);
    check({t, "_word_rdy"}, word_rdy, 1);
    check({t, "_empty"}, ch_empty, 3'b111);
    check({t, "_full"}, ch_full, 3'b000);
    check({t, "_rr_vld"}, out_vld_r, 0);
    check({t, "_rr_ext_rdy"}, ext_rdy_r, 2'b11);
    check({t, "_rr_empty"}, ch_empty_r, 3'b111);
  endtask

  initial begin
    #12;
    check_reset("rst");
    rst_n = 1'b1;
    step();

    out_rdy = 1'b1;
    send_word(32'h11111111);
    send_word(32'h22222222);
    send_word(32'h33333333);
    send_word(32'h44444444);
    check("pack_vld_early", out_vld, 0);
    step();
    check("pack_vld", out_vld, 1);
    check("pack_flit", out_flit, 128'h44444444_33333333_22222222_11111111);
    check("pack_ch", out_ch, CH_LOCAL);
    step();
    check("pack_idle", out_vld, 0);

    send_word(32'h55555555);
    send_word(32'h66666666);
    send_word(32'h77777777);
    ext_flit = {128'hB1, 128'hA1};
    ext_vld = 2'b11;
    send_word(32'h88888888);
    ext_vld = 2'b00;
    check("strict_all_loaded", ch_empty, 3'b000);
    step();
    check("strict_ch_0", out_ch, CH_ACK);
    check("strict_flit_0", out_flit, 128'hA1);
    step();
    check("strict_ch_1", out_ch, CH_FWD);
    check("strict_flit_1", out_flit, 128'hB1);
    check("strict_rr_ch_1", out_ch_r, CH_FWD);
    step();
    check("strict_ch_2", out_ch, CH_LOCAL);
    check("strict_flit_2", out_flit, 128'h88888888_77777777_66666666_55555555);
    step();
    check("strict_idle", out_vld, 0);

    out_rdy = 1'b0;
    for (int r = 0; r < 3; r++) begin
      ext_flit = {128'(r + 'hB0), 128'(r + 'hA0)};
      ext_vld = 2'b11;
      send_word(32'hC0000000 + 32'(4 * r));
      ext_vld = 2'b00;
      for (int k = 1; k < 4; k++) send_word(32'hC0000000 + 32'(4 * r + k));
    end
    check("rr_loaded_empty", ch_empty_r, 3'b000);
    out_rdy = 1'b1;
    for (int j = 0; j < 9; j++) begin
      if (j > 0) step();
      check($sformatf("rr_seq_%0d", j), out_ch_r, exp_rr[j]);
      check($sformatf("st_seq_%0d", j), out_ch, exp_st[j]);
      if (j < 3) check($sformatf("st_flit_%0d", j), out_flit, 128'hA0 + j);
      else if (j < 6) check($sformatf("st_flit_%0d", j), out_flit, 128'hB0 + j - 3);
    end
    step();
    check("rr_idle", out_vld_r, 0);
    check("st_idle", out_vld, 0);

    out_rdy = 1'b0;
    ext_flit[127:0] = 128'hF0;
    ext_vld = 2'b01;
    step();
    ext_vld = 2'b00;
    step();
    check("full_hold_vld", out_vld, 1);
    check("full_hold_ch", out_ch, CH_ACK);
    for (int i = 0; i < 8; i++) begin
      ext_flit[255:128] = 128'hD0 + i;
      ext_vld = 2'b10;
      step();
    end
    ext_vld = 2'b00;
    check("full_flag", ch_full[1], 1);
    check("full_rdy", ext_rdy[1], 0);
    check("full_rr_flag", ch_full_r[1], 1);
    ext_flit[255:128] = 128'hEE;
    ext_vld = 2'b10;
    out_rdy = 1'b1;
    step();
    ext_vld = 2'b00;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain_ch_%0d", i), out_ch, CH_FWD);
      check($sformatf("drain_flit_%0d", i), out_flit, 128'hD0 + i);
      step();
    end
    check("drain_no_ninth", out_vld, 0);

    out_rdy = 1'b0;
    ext_flit = {128'h2B, 128'h2A};
    ext_vld = 2'b11;
    word_in = 32'hDEAD0001;
    word_vld = 1'b1;
    step();
    ext_vld = 2'b00;
    word_in = 32'hDEAD0002;
    step();
    word_vld = 1'b0;
    check("pre_clear_vld", out_vld, 1);
    check("pre_clear_empty", ch_empty, 3'b101);
    clear = 1'b1;
    word_vld = 1'b1;
    word_in = 32'h0BAD0BAD;
    ext_flit[127:0] = 128'hBAD;
    ext_vld = 2'b01;
    #1;
    check("clear_word_rdy", word_rdy, 0);
    check("clear_ext_rdy", ext_rdy, 2'b00);
    step();
    clear = 1'b0;
    word_vld = 1'b0;
    ext_vld = 2'b00;
    check("clear_vld", out_vld, 0);
    check("clear_empty", ch_empty, 3'b111);
    check("clear_rr_vld", out_vld_r, 0);
    out_rdy = 1'b1;
    send_word(32'h00000001);
    send_word(32'h00000002);
    send_word(32'h00000003);
    send_word(32'h00000004);
    check("clear_pack_early", out_vld, 0);
    step();
    check("clear_pack_vld", out_vld, 1);
    check("clear_pack_flit", out_flit, 128'h00000004_00000003_00000002_00000001);
    check("clear_pack_ch", out_ch, CH_LOCAL);
    step();

    out_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ext_flit = {128'(i + 'h60), 128'(i + 'h50)};
      ext_vld = 2'b11;
      step();
    end
    ext_vld = 2'b00;
    check("half_vld", out_vld, 1);
    check("half_empty", ch_empty, 3'b100);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset("async_rst");
    step();
    step();
    #3;
    rst_n = 1'b1;
    out_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("post_rst_vld_%0d", i), out_vld, 0);
      check($sformatf("post_rst_rr_vld_%0d", i), out_vld_r, 0);
    end
    check("post_rst_empty", ch_empty, 3'b111);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/noc_tx_scheduler.md
# noc_tx_scheduler

Parametrised transmit-side scheduler for the NoC node. It packs local WORD_W-bit words into flits and queues flits from NUM_CH channels in per-channel FIFOs with real full/empty backpressure. It arbitrates the channels in strict-priority or round-robin mode and presents one registered flit at a time to the UART transmitter. It replaces the fixed three-queue, fixed-depth transmit path of the NoC top level.

## Interface
- WORD_W, 32: width of local input word.
- WORDS_PER_FLIT, 4: words packed per flit; FLIT_W = WORD_W*WORDS_PER_FLIT.
- NUM_CH, 3: total channels; channels 0..NUM_CH-2 take whole flits externally, channel NUM_CH-1 is fed only by the word packer; ≥2.
- DEPTH, 8: entries per channel FIFO; power of two, ≥2.
- RR_MODE, 0: 0 = strict priority (lower index wins), 1 = round-robin.
- nocclk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush of all FIFOs, packer and output register.
- ext_flit  in  (NUM_CH-1)×FLIT_W  flit per external channel.
- ext_vld  in  NUM_CH-1  per-channel valid.
- ext_rdy  out  NUM_CH-1  per-channel ready = FIFO not full and not clear.
- word_in  in  WORD_W  local data word.
- word_vld  in  1  word valid.
- word_rdy  out  1  word ready.
- out_flit  out  FLIT_W  registered flit to UART tx.
- out_vld  out  1  registered valid.
- out_ch  out  $clog2(NUM_CH)  source channel of out_flit.
- out_rdy  in  1  UART tx ready.
- ch_empty, ch_full  out  NUM_CH each  per-FIFO status, combinational from counters.

## Operation
- Per-channel FIFO: head/tail pointers $clog2(DEPTH) bits, wrap naturally; count $clog2(DEPTH+1) bits. Full = count==DEPTH, empty = count==0.
- Push when vld&&rdy. Ready is !full only: no push into a full FIFO even when it pops the same cycle. Push and pop on a non-full, non-empty FIFO in the same cycle leave count unchanged.
- Packer: position counter 0..WORDS_PER_FLIT-1. Word k lands at bits [k*WORD_W +: WORD_W].
- word_rdy = !(position==WORDS_PER_FLIT-1 && ch_full[NUM_CH-1]) && !clear. Intermediate words are always accepted.
- On the last word accepted, the assembled flit pushes into channel NUM_CH-1 on the same edge and position returns to 0.
- Output register loads when !out_vld || out_rdy. The grant goes to the winning non-empty channel, which pops. If no channel is non-empty, out_vld is 0.
- Strict mode: lowest-index non-empty channel wins.
- RR mode: search starts at last_grant+1 modulo NUM_CH. last_grant updates only on an actual pop. last_grant resets to NUM_CH-1, so channel 0 gets first grant.
- clear: counters, pointers, position, out_vld and last_grant return to reset values on that edge. Pushes and word accepts in that cycle are dropped because rdy is low.
- Reset (any time, including mid-flit or mid-handshake) returns the same state. Partially packed words are discarded. FIFO storage is not reset.

## Timing
- Reset values: out_vld=0, out_flit=0, out_ch=0, ext_rdy=all 1, word_rdy=1, ch_empty=all 1, ch_full=all 0.
- Latency from external flit accepted at edge N to out_vld high: after edge N+1, if the queue is idle.
- Latency from last word accepted at edge N to out_vld high: after edge N+1.
- Throughput: one flit per cycle when out_rdy is held high.
- out_flit, out_ch and out_vld are stable while out_vld && !out_rdy.

## Structure
- Package types: flit_t (FLIT_W-wide for default parameters), channel index constants CH_ACK=0, CH_FWD=1, CH_LOCAL=2.
- Sub-module noc_flit_fifo (DEPTH, FLIT_W), instantiated NUM_CH times. The top level holds the packer, arbiter and output register.

## Test plan
- Reset, then 4 words 0x11111111..0x44444444 with out_rdy=1 -> out_flit=0x44444444_33333333_22222222_11111111, out_ch=2, out_vld high 2 cycles after the last word.
- Strict mode: ch0, ch1 and ch2 each hold one flit, out_rdy=1 -> output order ch0, ch1, ch2 on consecutive cycles.
- RR mode: all channels hold 3 flits each -> out_ch sequence 0,1,2,0,1,2,0,1,2.
- out_rdy=0 and 8 pushes on ch1 -> ch_full[1]=1, ext_rdy[1]=0. A 9th vld is not accepted; with out_rdy=1 the flits drain in push order.
- 2 words packed, then clear -> position resets. The next 4 words form a flit with no stale data, and out_vld=0 in the cycle after clear.
- Assert rst_n low while out_vld=1 and FIFOs are half full -> all outputs take reset values asynchronously and no flit is emitted after release.
